// File: rtl/writeback_stage.sv
// Writeback stage: register file, W-stage write-back, processor status and retirement counter.
// Revision: 1.0
`default_nettype none

module writeback_stage #(
    parameter int          NREG = 15,
    parameter logic [3:0]  RSP  = 4'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  stat_w,
    input  logic [3:0]  icode_w,
    input  logic [3:0]  ifun_w,
    input  logic        cnd_w,
    input  logic [3:0]  rA_w,
    input  logic [3:0]  rB_w,
    input  logic [63:0] valE_w,
    input  logic [63:0] valM_w,
    input  logic        stall_w,
    input  logic [3:0]  srcA,
    input  logic [3:0]  srcB,
    output logic [63:0] valA_rf,
    output logic [63:0] valB_rf,
    output logic [3:0]  dstE_w,
    output logic [3:0]  dstM_w,
    output logic [2:0]  proc_stat,
    output logic        halted,
    output logic [63:0] retired_count
);

    localparam logic [3:0] REG_NONE = 4'hF;
    localparam logic [3:0] NREG_IDX = 4'(NREG);

    localparam logic [2:0] STAT_BUB = 3'd0;
    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_INS = 3'd4;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        STOP = 1'b1
    } state_t;

    state_t      state_q;
    logic [63:0] regs_q [NREG];
    logic [2:0]  proc_stat_q;
    logic        halted_q;
    logic [63:0] retired_q;
    logic [63:0] retired_d;
    logic [2:0]  fault_stat_d;

    logic active;
    logic is_aok;
    logic is_fault;
    logic we_e;
    logic we_m;

    // ifun_w is carried only for interface symmetry with the other stages
    logic unused_ifun;
    assign unused_ifun = ^ifun_w;

    always_comb begin
        dstE_w = REG_NONE;
        case (icode_w)
            4'h2:                   dstE_w = cnd_w ? rB_w : REG_NONE;
            4'h3, 4'h6:             dstE_w = rB_w;
            4'h8, 4'h9, 4'hA, 4'hB: dstE_w = RSP;
            default:                dstE_w = REG_NONE;
        endcase
    end

    assign dstM_w = (icode_w == 4'h5 || icode_w == 4'hB) ? rA_w : REG_NONE;

    assign active   = (state_q == RUN) && !stall_w && (stat_w != STAT_BUB);
    assign is_aok   = (stat_w == STAT_AOK);
    assign is_fault = active && !is_aok;
    assign we_e     = active && is_aok && (dstE_w != REG_NONE) && (dstE_w < NREG_IDX);
    assign we_m     = active && is_aok && (dstM_w != REG_NONE) && (dstM_w < NREG_IDX);

    // Undefined status codes collapse to INS
    assign fault_stat_d = (stat_w > STAT_INS) ? STAT_INS : stat_w;
    assign retired_d    = retired_q + 64'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            proc_stat_q <= STAT_AOK;
            halted_q    <= 1'b0;
            retired_q   <= '0;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            if (is_fault) begin
                state_q     <= STOP;
                halted_q    <= 1'b1;
                proc_stat_q <= fault_stat_d;
            end
            if (active && (is_aok || stat_w == STAT_HLT)) begin
                retired_q <= retired_d;
            end
            // M port is applied last so popq %rsp leaves the loaded value
            for (int i = 0; i < NREG; i++) begin
                if (we_e && dstE_w == 4'(i)) regs_q[i] <= valE_w;
                if (we_m && dstM_w == 4'(i)) regs_q[i] <= valM_w;
            end
        end
    end

    assign valA_rf       = (srcA < NREG_IDX) ? regs_q[srcA] : 64'd0;
    assign valB_rf       = (srcB < NREG_IDX) ? regs_q[srcB] : 64'd0;
    assign proc_stat     = proc_stat_q;
    assign halted        = halted_q;
    assign retired_count = retired_q;

endmodule

`default_nettype wire

// File: tb/tb_writeback_stage.sv
// Directed testbench for writeback_stage.
// Revision: 1.0
`default_nettype none

module tb_writeback_stage;

    logic        clk;
    logic        rst_n;
    logic [2:0]  stat_w;
    logic [3:0]  icode_w;
    logic [3:0]  ifun_w;
    logic        cnd_w;
    logic [3:0]  rA_w;
    logic [3:0]  rB_w;
    logic [63:0] valE_w;
    logic [63:0] valM_w;
    logic        stall_w;
    logic [3:0]  srcA;
    logic [3:0]  srcB;
    logic [63:0] valA_rf;
    logic [63:0] valB_rf;
    logic [3:0]  dstE_w;
    logic [3:0]  dstM_w;
    logic [2:0]  proc_stat;
    logic        halted;
    logic [63:0] retired_count;

    int checks = 0;
    int errors = 0;

    writeback_stage #(.NREG(15), .RSP(4'd4)) dut (
        .clk(clk), .rst_n(rst_n), .stat_w(stat_w), .icode_w(icode_w), .ifun_w(ifun_w),
        .cnd_w(cnd_w), .rA_w(rA_w), .rB_w(rB_w), .valE_w(valE_w), .valM_w(valM_w),
        .stall_w(stall_w), .srcA(srcA), .srcB(srcB), .valA_rf(valA_rf), .valB_rf(valB_rf),
        .dstE_w(dstE_w), .dstM_w(dstM_w), .proc_stat(proc_stat), .halted(halted),
        .retired_count(retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_w(input logic [2:0] st, input logic [3:0] ic, input logic cn,
                         input logic [3:0] ra, input logic [3:0] rb,
                         input logic [63:0] ve, input logic [63:0] vm);
        stat_w = st; icode_w = ic; cnd_w = cn; rA_w = ra; rB_w = rb;
        valE_w = ve; valM_w = vm;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; stall_w = 1'b0; ifun_w = 4'h0;
        set_w(3'd0, 4'h0, 1'b0, 4'hF, 4'hF, 64'd0, 64'd0);
        srcA = 4'd2; srcB = 4'hF;
        #12;
        checks++; if (proc_stat !== 3'd1) begin errors++; $display("FAIL reset_stat: got %0d exp 1", proc_stat); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %0b exp 0", halted); end
        checks++; if (retired_count !== 64'd0) begin errors++; $display("FAIL reset_count: got %0d exp 0", retired_count); end
        checks++; if (valA_rf !== 64'd0) begin errors++; $display("FAIL reset_reg2: got %h exp 0", valA_rf); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_irmovq;
        set_w(3'd1, 4'h3, 1'b0, 4'hF, 4'd2, 64'h1234, 64'd0);
        srcA = 4'd2;
        #1;
        checks++; if (dstE_w !== 4'd2 || dstM_w !== 4'hF) begin errors++; $display("FAIL irmovq_dst: got E=%h M=%h exp E=2 M=f", dstE_w, dstM_w); end
        checks++; if (valA_rf !== 64'd0) begin errors++; $display("FAIL irmovq_nobypass: got %h exp 0", valA_rf); end
        step();
        checks++; if (valA_rf !== 64'h1234) begin errors++; $display("FAIL irmovq_reg2: got %h exp 1234", valA_rf); end
        checks++; if (retired_count !== 64'd1) begin errors++; $display("FAIL irmovq_count: got %0d exp 1", retired_count); end
        srcB = 4'hF;
        #1;
        checks++; if (valB_rf !== 64'd0) begin errors++; $display("FAIL read_none: got %h exp 0", valB_rf); end
    endtask

    task automatic test_popq_rsp;
        set_w(3'd1, 4'hB, 1'b0, 4'd4, 4'hF, 64'h100, 64'h55);
        srcB = 4'd4;
        #1;
        checks++; if (dstE_w !== 4'd4 || dstM_w !== 4'd4) begin errors++; $display("FAIL popq_dst: got E=%h M=%h exp 4 4", dstE_w, dstM_w); end
        step();
        checks++; if (valB_rf !== 64'h55) begin errors++; $display("FAIL popq_rsp: got %h exp 55", valB_rf); end
        set_w(3'd1, 4'hA, 1'b0, 4'd1, 4'hF, 64'h200, 64'h0);
        #1;
        checks++; if (dstE_w !== 4'd4 || dstM_w !== 4'hF) begin errors++; $display("FAIL pushq_dst: got E=%h M=%h exp 4 f", dstE_w, dstM_w); end
        step();
        checks++; if (valB_rf !== 64'h200) begin errors++; $display("FAIL pushq_rsp: got %h exp 200", valB_rf); end
        checks++; if (retired_count !== 64'd3) begin errors++; $display("FAIL popq_count: got %0d exp 3", retired_count); end
    endtask

    task automatic test_cmov;
        set_w(3'd1, 4'h2, 1'b0, 4'd1, 4'd3, 64'h9, 64'h0);
        srcA = 4'd3;
        #1;
        checks++; if (dstE_w !== 4'hF) begin errors++; $display("FAIL cmov_nc_dst: got %h exp f", dstE_w); end
        step();
        checks++; if (valA_rf !== 64'd0) begin errors++; $display("FAIL cmov_nc_reg3: got %h exp 0", valA_rf); end
        set_w(3'd1, 4'h2, 1'b1, 4'd1, 4'd3, 64'h7, 64'h0);
        step();
        checks++; if (valA_rf !== 64'h7) begin errors++; $display("FAIL cmov_c_reg3: got %h exp 7", valA_rf); end
        checks++; if (retired_count !== 64'd5) begin errors++; $display("FAIL cmov_count: got %0d exp 5", retired_count); end
    endtask

    task automatic test_mrmovq_opq;
        set_w(3'd1, 4'h5, 1'b0, 4'd1, 4'd7, 64'h11, 64'hAA);
        srcA = 4'd1; srcB = 4'd7;
        #1;
        checks++; if (dstE_w !== 4'hF || dstM_w !== 4'd1) begin errors++; $display("FAIL mrmovq_dst: got E=%h M=%h exp f 1", dstE_w, dstM_w); end
        step();
        checks++; if (valA_rf !== 64'hAA || valB_rf !== 64'd0) begin errors++; $display("FAIL mrmovq_regs: got r1=%h r7=%h exp aa 0", valA_rf, valB_rf); end
        set_w(3'd1, 4'h6, 1'b0, 4'd1, 4'd5, 64'h99, 64'h33);
        srcB = 4'd5;
        step();
        checks++; if (valB_rf !== 64'h99 || valA_rf !== 64'hAA) begin errors++; $display("FAIL opq_regs: got r5=%h r1=%h exp 99 aa", valB_rf, valA_rf); end
        set_w(3'd1, 4'h1, 1'b1, 4'd6, 4'd6, 64'h1, 64'h2);
        #1;
        checks++; if (dstE_w !== 4'hF || dstM_w !== 4'hF) begin errors++; $display("FAIL nop_dst: got E=%h M=%h exp f f", dstE_w, dstM_w); end
        step();
        checks++; if (retired_count !== 64'd8) begin errors++; $display("FAIL nop_count: got %0d exp 8", retired_count); end
    endtask

    task automatic test_bubble_stall;
        set_w(3'd0, 4'h3, 1'b0, 4'hF, 4'd6, 64'h77, 64'h0);
        srcA = 4'd6;
        step();
        checks++; if (valA_rf !== 64'd0 || retired_count !== 64'd8) begin errors++; $display("FAIL bubble: got r6=%h cnt=%0d exp 0 8", valA_rf, retired_count); end
        stat_w = 3'd1; stall_w = 1'b1;
        step();
        checks++; if (valA_rf !== 64'd0 || retired_count !== 64'd8) begin errors++; $display("FAIL stall: got r6=%h cnt=%0d exp 0 8", valA_rf, retired_count); end
        stall_w = 1'b0;
        step();
        checks++; if (valA_rf !== 64'h77 || retired_count !== 64'd9) begin errors++; $display("FAIL unstall: got r6=%h cnt=%0d exp 77 9", valA_rf, retired_count); end
    endtask

    task automatic test_adr;
        set_w(3'd3, 4'h5, 1'b0, 4'd1, 4'hF, 64'h0, 64'hBB);
        srcA = 4'd1;
        step();
        checks++; if (valA_rf !== 64'hAA) begin errors++; $display("FAIL adr_reg1: got %h exp aa", valA_rf); end
        checks++; if (proc_stat !== 3'd3 || halted !== 1'b1) begin errors++; $display("FAIL adr_stat: got stat=%0d halted=%0b exp 3 1", proc_stat, halted); end
        checks++; if (retired_count !== 64'd9) begin errors++; $display("FAIL adr_count: got %0d exp 9", retired_count); end
        set_w(3'd1, 4'h3, 1'b0, 4'hF, 4'd1, 64'hCC, 64'h0);
        step();
        checks++; if (valA_rf !== 64'hAA || retired_count !== 64'd9 || proc_stat !== 3'd3) begin errors++; $display("FAIL stop_hold: got r1=%h cnt=%0d stat=%0d exp aa 9 3", valA_rf, retired_count, proc_stat); end
    endtask

    task automatic test_reset_in_stop;
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (valA_rf !== 64'd0 || proc_stat !== 3'd1 || halted !== 1'b0 || retired_count !== 64'd0) begin
            errors++; $display("FAIL async_reset: got r1=%h stat=%0d halted=%0b cnt=%0d exp 0 1 0 0", valA_rf, proc_stat, halted, retired_count);
        end
        set_w(3'd1, 4'h3, 1'b0, 4'hF, 4'd2, 64'h5, 64'h0);
        #1;
        rst_n = 1'b1;
        srcA = 4'd2;
        step();
        checks++; if (valA_rf !== 64'h5 || retired_count !== 64'd1) begin errors++; $display("FAIL resume: got r2=%h cnt=%0d exp 5 1", valA_rf, retired_count); end
    endtask

    task automatic test_halt;
        set_w(3'd2, 4'h3, 1'b0, 4'hF, 4'd2, 64'hDEAD, 64'h0);
        step();
        checks++; if (retired_count !== 64'd2 || proc_stat !== 3'd2 || halted !== 1'b1) begin
            errors++; $display("FAIL halt: got cnt=%0d stat=%0d halted=%0b exp 2 2 1", retired_count, proc_stat, halted);
        end
        checks++; if (valA_rf !== 64'h5) begin errors++; $display("FAIL halt_nowrite: got %h exp 5", valA_rf); end
        set_w(3'd1, 4'h3, 1'b0, 4'hF, 4'd2, 64'h6, 64'h0);
        step();
        checks++; if (retired_count !== 64'd2 || valA_rf !== 64'h5) begin errors++; $display("FAIL halt_hold: got cnt=%0d r2=%h exp 2 5", retired_count, valA_rf); end
    endtask

    task automatic test_bad_stat;
        #2;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        set_w(3'd6, 4'h3, 1'b0, 4'hF, 4'd2, 64'h8, 64'h0);
        step();
        checks++; if (proc_stat !== 3'd4 || halted !== 1'b1 || retired_count !== 64'd0 || valA_rf !== 64'd0) begin
            errors++; $display("FAIL bad_stat: got stat=%0d halted=%0b cnt=%0d r2=%h exp 4 1 0 0", proc_stat, halted, retired_count, valA_rf);
        end
        #2;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        set_w(3'd4, 4'h0, 1'b0, 4'hF, 4'hF, 64'h0, 64'h0);
        step();
        checks++; if (proc_stat !== 3'd4 || halted !== 1'b1 || retired_count !== 64'd0) begin
            errors++; $display("FAIL ins_stat: got stat=%0d halted=%0b cnt=%0d exp 4 1 0", proc_stat, halted, retired_count);
        end
    endtask

    initial begin
        test_reset();
        test_irmovq();
        test_popq_rsp();
        test_cmov();
        test_mrmovq_opq();
        test_bubble_stall();
        test_adr();
        test_reset_in_stop();
        test_halt();
        test_bad_stat();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 The block SHALL have these parameters: NREG, default 15, number of architectural registers; RSP, default 4, stack-pointer register index.
REQ-002 The block SHALL have these ports (name direction width meaning):
  clk  input  1  single clock, all state changes on rising edge
  rst_n  input  1  asynchronous active-low reset
  stat_w  input  3  W-register status: 0 BUB, 1 AOK, 2 HLT, 3 ADR, 4 INS
  icode_w  input  4  W-register instruction code
  ifun_w  input  4  W-register function code (unused, kept for interface symmetry)
  cnd_w  input  1  W-register condition flag
  rA_w  input  4  W-register rA field
  rB_w  input  4  W-register rB field
  valE_w  input  64  W-register ALU result
  valM_w  input  64  W-register memory result
  stall_w  input  1  W stage stalled this cycle
  srcA  input  4  decode read address A
  srcB  input  4  decode read address B
  valA_rf  output  64  register-file read data A
  valB_rf  output  64  register-file read data B
  dstE_w  output  4  E write destination this cycle (0xF = none)
  dstM_w  output  4  M write destination this cycle (0xF = none)
  proc_stat  output  3  architectural processor status
  halted  output  1  processor stopped
  retired_count  output  64  retired-instruction counter

Function
REQ-003 The block SHALL hold NREG 64-bit registers, indices 0..14; index 0xF SHALL mean "no register".
REQ-004 dstE_w SHALL be combinational: rB_w for cmovXX (icode 2) when cnd_w=1 (0xF when cnd_w=0); rB_w for irmovq (3) and OPq (6); RSP for call (8), ret (9), pushq (0xA), popq (0xB); 0xF otherwise.
REQ-005 dstM_w SHALL be combinational: rA_w for mrmovq (5) and popq (0xB); 0xF otherwise.
REQ-006 The controller SHALL have two states, RUN and STOP.
REQ-007 A W instruction SHALL be "active" when state=RUN, stall_w=0 and stat_w != BUB.
REQ-008 On a rising edge with an active instruction and stat_w=AOK, the block SHALL write valE_w to dstE_w and valM_w to dstM_w, each only if the destination != 0xF.
REQ-009 When dstE_w = dstM_w != 0xF, valM_w SHALL be the value written (popq %rsp case).
REQ-010 An active instruction with stat_w in {HLT, ADR, INS} SHALL perform no register write, SHALL latch stat_w into proc_stat, and SHALL move the state to STOP on that edge.
REQ-011 Any stat_w value 5..7 on an active instruction SHALL be treated as INS: proc_stat := 4, state := STOP.
REQ-012 In STOP, all register writes and counter updates SHALL be suppressed, and proc_stat SHALL hold until reset.
REQ-013 halted SHALL equal 1 exactly when the state is STOP.
REQ-014 retired_count SHALL increment by 1 on each edge with an active instruction whose stat_w is AOK or HLT, and SHALL wrap from 2^64-1 to 0.
REQ-015 valA_rf and valB_rf SHALL be combinational reads of the current register contents, returning 0 for address 0xF; a same-cycle write SHALL become visible only after the edge (no internal bypass).
REQ-016 While stall_w=1, all state SHALL hold and the W instruction SHALL be neither written nor counted.

Reset
REQ-017 While rst_n=0, asynchronously: all registers = 0, state = RUN, proc_stat = 1 (AOK), halted = 0, retired_count = 0.
REQ-018 Reset asserted mid-operation, including in STOP, SHALL return the block to the REQ-017 values; operation SHALL resume on the first rising edge after rst_n=1.

Verification
REQ-019 irmovq: stat_w=1, icode_w=3, rB_w=2, valE_w=0x1234, one edge -> reg2=0x1234, srcA=2 reads 0x1234, retired_count=1.
REQ-020 popq %rsp: icode_w=0xB, rA_w=4, valE_w=0x100, valM_w=0x55 -> reg4=0x55; dstE_w=dstM_w=4.
REQ-021 cmovXX with cnd_w=0, rB_w=3 -> dstE_w=0xF and reg3 unchanged; with cnd_w=1 and valE_w=7 -> reg3=7.
REQ-022 stat_w=3 (ADR) on mrmovq with rA_w=1 -> reg1 unchanged, proc_stat=3, halted=1; a following AOK irmovq -> no write and retired_count unchanged.
REQ-023 Bubble (stat_w=0) and stall_w=1 cycles with icode_w=3 -> no writes and no counter change; halt (stat_w=2) -> retired_count+1, proc_stat=2, halted=1.
REQ-024 rst_n pulsed low between edges while in STOP -> immediately all registers=0, proc_stat=1, halted=0, retired_count=0.
